counter_step_decoder: RTL

- Receive-side companion to the team's up/down step counters: samples a WIDTH-bit counter value and reconstructs the step command that produced each transition.
- Reports direction (up/down) and step size (1 or 2) for every legal transition.
- Flags illegal jumps, tracks lock status and keeps a saturating error count.
- Sits downstream of a counter for self-checking and monitoring in lab designs.

---
 rtl/counter_step_decoder_if.sv | 35 +++
 rtl/counter_step_decoder.sv | 109 ++++++++++
 2 files changed

// File: rtl/counter_step_decoder_if.sv
// Bus between a counter under observation and counter_step_decoder.
// Optional statistics ports are present only when COUNTER_STEP_DECODER_STATS_EN is defined.
interface counter_step_decoder_if #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
);
  logic             en;
  logic [WIDTH-1:0] cnt;
  logic             valid;
  logic             dir_down;
  logic             step2;
  logic             err;
  logic             locked;
  logic [ERRW-1:0]  err_count;
`ifdef COUNTER_STEP_DECODER_STATS_EN
  logic [ERRW-1:0]  up_events;
  logic [ERRW-1:0]  down_events;
`endif

  modport master (
    output en, cnt,
    input  valid, dir_down, step2, err, locked, err_count
`ifdef COUNTER_STEP_DECODER_STATS_EN
    , up_events, down_events
`endif
  );

  modport slave (
    input  en, cnt,
    output valid, dir_down, step2, err, locked, err_count
`ifdef COUNTER_STEP_DECODER_STATS_EN
    , up_events, down_events
`endif
  );
endinterface

// File: rtl/counter_step_decoder.sv
// Reconstructs up/down, step-1/step-2 commands from a sampled counter value.
// Optional macro COUNTER_STEP_DECODER_STATS_EN adds saturating up/down event counters.
module counter_step_decoder #(
  parameter int WIDTH    = 4,  // >= 3 so that +2 and -2 differ
  parameter int LOCK_CNT = 3,  // >= 1
  parameter int ERRW     = 8
) (
  input logic                   clk,
  input logic                   rst,
  counter_step_decoder_if.slave bus
);
  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] prev, prev_nx;
  logic [GW-1:0]    good, good_nx;
  logic             valid_nx, dir_nx, step2_nx, err_nx, locked_nx;
  logic [ERRW-1:0]  errc_nx;

  logic [WIDTH-1:0] delta;
  logic             is_hold, is_legal, is_down, is_step2;

  // Modular subtraction makes wrap-around steps (15->1, 0->14) fall out naturally.
  assign delta    = bus.cnt - prev;
  assign is_hold  = (delta == '0);
  assign is_down  = (delta == WIDTH'(-1)) || (delta == WIDTH'(-2));
  assign is_step2 = (delta == WIDTH'(2))  || (delta == WIDTH'(-2));
  assign is_legal = (delta == WIDTH'(1))  || (delta == WIDTH'(2)) || is_down;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx  = state;
    prev_nx   = prev;
    good_nx   = good;
    valid_nx  = 1'b0;
    err_nx    = 1'b0;
    dir_nx    = bus.dir_down;
    step2_nx  = bus.step2;
    locked_nx = bus.locked;
    errc_nx   = bus.err_count;

    if (bus.en) begin
      prev_nx = bus.cnt;
      if (state == IDLE) begin
        state_nx = ACQ;
      end else if (!is_hold) begin
        if (is_legal) begin
          valid_nx = 1'b1;
          dir_nx   = is_down;
          step2_nx = is_step2;
          if (state == ACQ) begin
            if (good + 1'b1 == GW'(LOCK_CNT)) begin
              state_nx  = LOCK;
              locked_nx = 1'b1;
              good_nx   = '0;
            end else begin
              good_nx = good + 1'b1;
            end
          end
        end else begin
          err_nx    = 1'b1;
          good_nx   = '0;
          state_nx  = ACQ;
          locked_nx = 1'b0;
          if (bus.err_count != '1) errc_nx = bus.err_count + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      prev          <= '0;
      good          <= '0;
      bus.valid     <= 1'b0;
      bus.dir_down  <= 1'b0;
      bus.step2     <= 1'b0;
      bus.err       <= 1'b0;
      bus.locked    <= 1'b0;
      bus.err_count <= '0;
    end else begin
      state         <= state_nx;
      prev          <= prev_nx;
      good          <= good_nx;
      bus.valid     <= valid_nx;
      bus.dir_down  <= dir_nx;
      bus.step2     <= step2_nx;
      bus.err       <= err_nx;
      bus.locked    <= locked_nx;
      bus.err_count <= errc_nx;
    end
  end

`ifdef COUNTER_STEP_DECODER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.up_events   <= '0;
      bus.down_events <= '0;
    end else if (valid_nx) begin
      if (!is_down && bus.up_events != '1)  bus.up_events   <= bus.up_events + 1'b1;
      if (is_down && bus.down_events != '1) bus.down_events <= bus.down_events + 1'b1;
    end
  end
`endif
endmodule
